// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA job sequencer: sequencer states and default sizes.
package rsa_pkg;

   localparam int RSA_WIDTH           = 128;
   localparam int RSA_MSG_WIDTH       = 2 * RSA_WIDTH;
   localparam int RSA_TIMEOUT_CYCLES  = 1048576;
   localparam int RSA_CNT_W           = 21;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      INV_START = 3'd1,
      INV_WAIT  = 3'd2,
      EXP_START = 3'd3,
      EXP_WAIT  = 3'd4,
      RESP      = 3'd5
   } seq_state_t;

endpackage

// File: rtl/rsa_key_cache.sv
// Single-entry key cache: remembers {p, q, decrypt} of the last job whose inverter
// phase completed, so a repeat job can skip straight to modular exponentiation.
// A flush while the sequencer is busy is parked and applied when it returns to idle.
module rsa_key_cache import rsa_pkg::*; #(
   parameter int TAG_W = 2 * RSA_WIDTH + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [TAG_W-1:0] lookup_tag,
   input  logic [TAG_W-1:0] store_tag,
   input  logic             store,
   input  logic             invalidate,
   input  logic             flush,
   input  logic             idle,
   input  logic             release_busy,
   output logic             hit
);

   logic [TAG_W-1:0] tag_q, tag_d;
   logic             key_valid_q, key_valid_d;
   logic             pend_flush_q, pend_flush_d;

   // Next-state of the cache entry; later rules override earlier ones so that a
   // parked flush lands after any tag store made during the same job.
   always_comb begin
      tag_d        = tag_q;
      key_valid_d  = key_valid_q;
      pend_flush_d = pend_flush_q;
      if (store) begin
         tag_d       = store_tag;
         key_valid_d = 1'b1;
      end
      if (invalidate) begin
         key_valid_d = 1'b0;
      end
      if (idle) begin
         if (flush) begin
            key_valid_d  = 1'b0;
            pend_flush_d = 1'b0;
         end
      end else if (flush) begin
         pend_flush_d = 1'b1;
      end
      if (release_busy && (pend_flush_q || flush)) begin
         key_valid_d  = 1'b0;
         pend_flush_d = 1'b0;
      end
   end

   // A flush arriving together with the lookup always forces a miss.
   assign hit = key_valid_q && (tag_q == lookup_tag) && !flush;

   // Cache entry registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tag_q        <= '0;
         key_valid_q  <= 1'b0;
         pend_flush_q <= 1'b0;
      end else begin
         tag_q        <= tag_d;
         key_valid_q  <= key_valid_d;
         pend_flush_q <= pend_flush_d;
      end
   end

endmodule

// File: rtl/rsa_job_sequencer.sv
// Front-end controller for one RSA core: accepts a job, pulses the inverter and
// mod-exp starts in turn (skipping the inverter on a key-cache hit), guards each
// wait phase with a watchdog, and returns the result on a valid/ready channel.
module rsa_job_sequencer import rsa_pkg::*; #(
   parameter int WIDTH          = RSA_WIDTH,
   parameter int TIMEOUT_CYCLES = RSA_TIMEOUT_CYCLES,
   parameter int CNT_W          = RSA_CNT_W
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [WIDTH-1:0]   req_p,
   input  logic [WIDTH-1:0]   req_q,
   input  logic [2*WIDTH-1:0] req_msg,
   input  logic               req_decrypt,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [2*WIDTH-1:0] rsp_msg,
   output logic               rsp_error,
   output logic               rsp_key_hit,
   input  logic               key_flush,
   output logic [WIDTH-1:0]   core_p,
   output logic [WIDTH-1:0]   core_q,
   output logic [2*WIDTH-1:0] core_msg_in,
   output logic               core_encrypt_decrypt,
   output logic               core_reset_inverter,
   output logic               core_reset_mod_exp,
   input  logic               core_inverter_finish,
   input  logic               core_mod_exp_finish,
   input  logic [2*WIDTH-1:0] core_msg_out
);

   localparam int TAG_W = 2 * WIDTH + 1;
   localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] WD_MAX   = '1;

   seq_state_t         state_q, state_d;
   logic [WIDTH-1:0]   core_p_q, core_p_d;
   logic [WIDTH-1:0]   core_q_q, core_q_d;
   logic [2*WIDTH-1:0] core_msg_q, core_msg_d;
   logic               core_dec_q, core_dec_d;
   logic [2*WIDTH-1:0] rsp_msg_q, rsp_msg_d;
   logic               rsp_error_q, rsp_error_d;
   logic               rsp_key_hit_q, rsp_key_hit_d;
   logic [CNT_W-1:0]   wd_q, wd_d;
   logic [CNT_W-1:0]   wd_inc;
   logic               guard;
   logic               timeout;
   logic               cache_hit;
   logic               cache_store;
   logic               cache_invalidate;

   rsa_key_cache #(
      .TAG_W (TAG_W)
   ) u_key_cache (
      .clk          (clk),
      .reset_n      (reset_n),
      .lookup_tag   ({req_p, req_q, req_decrypt}),
      .store_tag    ({core_p_q, core_q_q, core_dec_q}),
      .store        (cache_store),
      .invalidate   (cache_invalidate),
      .flush        (key_flush),
      .idle         (state_q == IDLE),
      .release_busy ((state_q == RESP) && rsp_ready),
      .hit          (cache_hit)
   );

   // Sequencer next-state, job capture, watchdog and response capture.
   always_comb begin
      state_d          = state_q;
      core_p_d         = core_p_q;
      core_q_d         = core_q_q;
      core_msg_d       = core_msg_q;
      core_dec_d       = core_dec_q;
      rsp_msg_d        = rsp_msg_q;
      rsp_error_d      = rsp_error_q;
      rsp_key_hit_d    = rsp_key_hit_q;
      wd_d             = wd_q;
      cache_store      = 1'b0;
      cache_invalidate = 1'b0;
      wd_inc           = (wd_q == WD_MAX) ? wd_q : wd_q + CNT_W'(1);
      guard            = (wd_q == '0);
      timeout          = (wd_q >= WD_LIMIT);

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               core_p_d      = req_p;
               core_q_d      = req_q;
               core_msg_d    = req_msg;
               core_dec_d    = req_decrypt;
               rsp_error_d   = 1'b0;
               rsp_key_hit_d = cache_hit;
               state_d       = cache_hit ? EXP_START : INV_START;
            end
         end
         INV_START: begin
            wd_d    = '0;
            state_d = INV_WAIT;
         end
         INV_WAIT: begin
            wd_d = wd_inc;
            if (!guard && core_inverter_finish) begin
               cache_store = 1'b1;
               state_d     = EXP_START;
            end else if (timeout) begin
               rsp_error_d      = 1'b1;
               rsp_msg_d        = '0;
               cache_invalidate = 1'b1;
               state_d          = RESP;
            end
         end
         EXP_START: begin
            wd_d    = '0;
            state_d = EXP_WAIT;
         end
         EXP_WAIT: begin
            wd_d = wd_inc;
            if (!guard && core_mod_exp_finish) begin
               rsp_msg_d = core_msg_out;
               state_d   = RESP;
            end else if (timeout) begin
               rsp_error_d      = 1'b1;
               rsp_msg_d        = '0;
               cache_invalidate = 1'b1;
               state_d          = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Sequencer, job and response registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         core_p_q      <= '0;
         core_q_q      <= '0;
         core_msg_q    <= '0;
         core_dec_q    <= 1'b0;
         rsp_msg_q     <= '0;
         rsp_error_q   <= 1'b0;
         rsp_key_hit_q <= 1'b0;
         wd_q          <= '0;
      end else begin
         state_q       <= state_d;
         core_p_q      <= core_p_d;
         core_q_q      <= core_q_d;
         core_msg_q    <= core_msg_d;
         core_dec_q    <= core_dec_d;
         rsp_msg_q     <= rsp_msg_d;
         rsp_error_q   <= rsp_error_d;
         rsp_key_hit_q <= rsp_key_hit_d;
         wd_q          <= wd_d;
      end
   end

   assign req_ready            = (state_q == IDLE);
   assign rsp_valid            = (state_q == RESP);
   assign rsp_msg              = rsp_msg_q;
   assign rsp_error            = rsp_error_q;
   assign rsp_key_hit          = rsp_key_hit_q;
   assign core_p               = core_p_q;
   assign core_q               = core_q_q;
   assign core_msg_in          = core_msg_q;
   assign core_encrypt_decrypt = core_dec_q;
   assign core_reset_inverter  = (state_q == INV_START);
   assign core_reset_mod_exp   = (state_q == EXP_START);

endmodule

// File: tb/tb_rsa_job_sequencer.sv
// Bench for rsa_job_sequencer: a behavioural core (inverter 40 cycles, mod-exp
// 100 cycles, finish held until the next start) plus a one-entry key-cache
// reference model. A second instance with a 64-cycle watchdog and a core that
// never finishes covers the abort path.
module tb_rsa_job_sequencer;

   localparam int W       = 128;
   localparam int MW      = 256;
   localparam int INV_LAT = 40;
   localparam int EXP_LAT = 100;
   // Pulse cycle, guard cycle, core's one-cycle start acknowledge, then capture.
   localparam int INV_PHASE = INV_LAT + 3;
   localparam int EXP_PHASE = EXP_LAT + 3;
   localparam int TO_CYCLES = 64;

   localparam logic [W-1:0] P1 = 128'd113680897410347;
   localparam logic [W-1:0] Q1 = 128'd7999808077935876437321;
   localparam logic [W-1:0] P2 = 128'h0123_4567_89ab_cdef_0f1e_2d3c_4b5a_6978;
   localparam logic [W-1:0] Q2 = 128'hfedc_ba98_7654_3210_1122_3344_5566_7788;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic          req_valid = 1'b0, req_valid_to = 1'b0;
   logic [W-1:0]  req_p = '0, req_q = '0;
   logic [MW-1:0] req_msg = '0;
   logic          req_decrypt = 1'b0;
   logic          rsp_ready = 1'b0, rsp_ready_to = 1'b0;
   logic          key_flush = 1'b0;

   logic          req_ready, rsp_valid, rsp_error, rsp_key_hit;
   logic [MW-1:0] rsp_msg, core_msg_in;
   logic [W-1:0]  core_p, core_q;
   logic          core_encrypt_decrypt, core_reset_inverter, core_reset_mod_exp;

   logic          req_ready_to, rsp_valid_to, rsp_error_to, rsp_key_hit_to;
   logic [MW-1:0] rsp_msg_to, core_msg_in_to;
   logic [W-1:0]  core_p_to, core_q_to;
   logic          core_encrypt_decrypt_to, core_reset_inverter_to, core_reset_mod_exp_to;

   int            inv_cnt = -1, exp_cnt = -1;
   logic          inv_pulse_d = 1'b0, exp_pulse_d = 1'b0;
   logic          inv_fin = 1'b0, exp_fin = 1'b0;
   logic [MW-1:0] exp_out = '0;

   int            errors = 0;
   int            checks = 0;
   bit            ref_valid = 1'b0;
   logic [2*W:0]  ref_tag = '0;

   always #5 clk = ~clk;

   rsa_job_sequencer dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_p(req_p), .req_q(req_q), .req_msg(req_msg), .req_decrypt(req_decrypt),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_msg(rsp_msg),
      .rsp_error(rsp_error), .rsp_key_hit(rsp_key_hit), .key_flush(key_flush),
      .core_p(core_p), .core_q(core_q), .core_msg_in(core_msg_in),
      .core_encrypt_decrypt(core_encrypt_decrypt),
      .core_reset_inverter(core_reset_inverter), .core_reset_mod_exp(core_reset_mod_exp),
      .core_inverter_finish(inv_fin), .core_mod_exp_finish(exp_fin),
      .core_msg_out(exp_out)
   );

   rsa_job_sequencer #(.TIMEOUT_CYCLES(TO_CYCLES), .CNT_W(7)) dut_to (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid_to), .req_ready(req_ready_to),
      .req_p(req_p), .req_q(req_q), .req_msg(req_msg), .req_decrypt(req_decrypt),
      .rsp_valid(rsp_valid_to), .rsp_ready(rsp_ready_to), .rsp_msg(rsp_msg_to),
      .rsp_error(rsp_error_to), .rsp_key_hit(rsp_key_hit_to), .key_flush(key_flush),
      .core_p(core_p_to), .core_q(core_q_to), .core_msg_in(core_msg_in_to),
      .core_encrypt_decrypt(core_encrypt_decrypt_to),
      .core_reset_inverter(core_reset_inverter_to), .core_reset_mod_exp(core_reset_mod_exp_to),
      .core_inverter_finish(1'b0), .core_mod_exp_finish(1'b0),
      .core_msg_out('0)
   );

   // Stand-in for the core's arithmetic: any deterministic function of the job.
   function automatic logic [MW-1:0] core_fn(input logic [W-1:0] p, input logic [W-1:0] q,
                                             input logic [MW-1:0] m, input logic d);
      core_fn = (m ^ {p, q}) + (d ? 256'd3 : 256'd5);
   endfunction

   // Behavioural core: acknowledges a start one cycle late, so finish from the
   // previous job is still visible during the sequencer's first wait cycle.
   always @(posedge clk) begin
      inv_pulse_d <= core_reset_inverter;
      exp_pulse_d <= core_reset_mod_exp;
      if (inv_pulse_d) begin
         inv_cnt <= 0;
         inv_fin <= 1'b0;
      end else if (inv_cnt >= 0 && !inv_fin) begin
         if (inv_cnt + 1 == INV_LAT) inv_fin <= 1'b1;
         inv_cnt <= inv_cnt + 1;
      end
      if (exp_pulse_d) begin
         exp_cnt <= 0;
         exp_fin <= 1'b0;
      end else if (exp_cnt >= 0 && !exp_fin) begin
         if (exp_cnt + 1 == EXP_LAT) begin
            exp_fin <= 1'b1;
            exp_out <= core_fn(core_p, core_q, core_msg_in, core_encrypt_decrypt);
         end
         exp_cnt <= exp_cnt + 1;
      end
   end

   // Runs one job on the main instance and reports what was observed; cycle
   // numbers count from the first cycle after the accepting edge (n=0).
   task automatic run_job(input logic [W-1:0] p, input logic [W-1:0] q, input logic [MW-1:0] m,
                          input logic d, input logic flush, input int hold, input int flush_at,
                          output bit tmo, output int inv_n, output int inv_at, output int exp_at,
                          output int rsp_at, output int busy_rdy, output logic [MW-1:0] r_msg,
                          output logic r_err, output logic r_hit, output bit stable,
                          output logic rdy_after);
      int w;
      tmo = 0; inv_n = 0; inv_at = -1; exp_at = -1; rsp_at = -1; busy_rdy = 0;
      r_msg = '0; r_err = 1'b0; r_hit = 1'b0; stable = 1; rdy_after = 1'b0;
      @(negedge clk);
      w = 0;
      while (!req_ready && w < 300) begin
         @(negedge clk);
         w++;
      end
      if (!req_ready) begin
         tmo = 1;
         return;
      end
      req_p = p; req_q = q; req_msg = m; req_decrypt = d;
      req_valid = 1'b1; key_flush = flush;
      @(negedge clk);
      req_valid = 1'b0; key_flush = 1'b0;
      req_p = {4{$urandom}}; req_q = {4{$urandom}}; req_msg = {8{$urandom}};
      req_decrypt = 1'($urandom_range(0, 1));
      for (int n = 0; n < 400; n++) begin
         if (n > 0) @(negedge clk);
         if (core_reset_inverter) begin inv_n++; inv_at = n; end
         if (core_reset_mod_exp) exp_at = n;
         if (rsp_valid) begin rsp_at = n; break; end
         if (req_ready) busy_rdy++;
         key_flush = (n == flush_at);
      end
      key_flush = 1'b0;
      if (rsp_at < 0) begin
         tmo = 1;
         return;
      end
      r_msg = rsp_msg; r_err = rsp_error; r_hit = rsp_key_hit;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (!rsp_valid || rsp_msg !== r_msg || rsp_error !== r_err ||
             rsp_key_hit !== r_hit || req_ready !== 1'b0) stable = 0;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      rdy_after = req_ready;
   endtask

   task automatic test_reset();
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({req_ready, rsp_valid, rsp_error, rsp_key_hit, core_reset_inverter,
           core_reset_mod_exp, core_encrypt_decrypt} !== 7'b1000000) begin
         errors++;
         $display("[TB] FAIL reset_ctrl got=%b want=1000000", {req_ready, rsp_valid, rsp_error,
                  rsp_key_hit, core_reset_inverter, core_reset_mod_exp, core_encrypt_decrypt});
      end
      checks++;
      if (rsp_msg !== '0 || core_p !== '0 || core_q !== '0 || core_msg_in !== '0) begin
         errors++;
         $display("[TB] FAIL reset_data rsp_msg=%h core_p=%h want all zero", rsp_msg, core_p);
      end
      @(negedge clk);
      reset_n = 1'b1;
      ref_valid = 1'b0;
   endtask

   task automatic test_miss_encrypt();
      bit tmo, st; int inv_n, inv_at, exp_at, rsp_at, br; logic [MW-1:0] rm; logic re, rh, ra;
      logic [MW-1:0] m = 256'hb3000000000000;
      run_job(P1, Q1, m, 1'b0, 1'b0, 0, -1, tmo, inv_n, inv_at, exp_at, rsp_at, br, rm, re, rh, st, ra);
      checks++;
      if (tmo || inv_n != 1 || inv_at != 0 || exp_at != INV_PHASE || rsp_at != INV_PHASE + EXP_PHASE) begin
         errors++;
         $display("[TB] FAIL miss_timing tmo=%0d inv_n=%0d inv_at=%0d exp_at=%0d rsp_at=%0d want 0/1/0/%0d/%0d",
                  tmo, inv_n, inv_at, exp_at, rsp_at, INV_PHASE, INV_PHASE + EXP_PHASE);
      end
      checks++;
      if (rm !== core_fn(P1, Q1, m, 1'b0) || re !== 1'b0 || rh !== 1'b0) begin
         errors++;
         $display("[TB] FAIL miss_rsp msg=%h err=%b hit=%b want msg=%h err=0 hit=0", rm, re, rh,
                  core_fn(P1, Q1, m, 1'b0));
      end
      checks++;
      if (br != 0 || ra !== 1'b1) begin
         errors++;
         $display("[TB] FAIL miss_ready busy_ready=%0d ready_after=%b want 0/1", br, ra);
      end
      checks++;
      if (core_p !== P1 || core_q !== Q1 || core_msg_in !== m || core_encrypt_decrypt !== 1'b0) begin
         errors++;
         $display("[TB] FAIL core_hold core_p=%h core_q=%h want %h %h", core_p, core_q, P1, Q1);
      end
      ref_valid = 1'b1; ref_tag = {P1, Q1, 1'b0};
   endtask

   task automatic test_hit();
      bit tmo, st; int inv_n, inv_at, exp_at, rsp_at, br; logic [MW-1:0] rm; logic re, rh, ra;
      logic [MW-1:0] m = 256'he149;
      run_job(P1, Q1, m, 1'b0, 1'b0, 0, -1, tmo, inv_n, inv_at, exp_at, rsp_at, br, rm, re, rh, st, ra);
      checks++;
      if (tmo || inv_n != 0 || exp_at != 0 || rsp_at != EXP_PHASE) begin
         errors++;
         $display("[TB] FAIL hit_timing tmo=%0d inv_n=%0d exp_at=%0d rsp_at=%0d want 0/0/0/%0d",
                  tmo, inv_n, exp_at, rsp_at, EXP_PHASE);
      end
      checks++;
      if (rm !== core_fn(P1, Q1, m, 1'b0) || re !== 1'b0 || rh !== 1'b1) begin
         errors++;
         $display("[TB] FAIL hit_rsp msg=%h err=%b hit=%b want msg=%h err=0 hit=1", rm, re, rh,
                  core_fn(P1, Q1, m, 1'b0));
      end
   endtask

   task automatic test_swapped_key();
      bit tmo, st; int inv_n, inv_at, exp_at, rsp_at, br; logic [MW-1:0] rm; logic re, rh, ra;
      logic [MW-1:0] m;
      for (int k = 0; k < 2; k++) begin
         m = {8{$urandom}};
         run_job(Q1, P1, m, 1'(k), 1'b0, 0, -1, tmo, inv_n, inv_at, exp_at, rsp_at, br, rm, re, rh, st, ra);
         checks++;
         if (tmo || inv_n != 1 || exp_at != INV_PHASE || rh !== 1'b0) begin
            errors++;
            $display("[TB] FAIL swap_miss dec=%0d inv_n=%0d exp_at=%0d hit=%b want 1/%0d/0",
                     k, inv_n, exp_at, rh, INV_PHASE);
         end
         checks++;
         if (rm !== core_fn(Q1, P1, m, 1'(k))) begin
            errors++;
            $display("[TB] FAIL swap_msg dec=%0d got=%h want=%h", k, rm, core_fn(Q1, P1, m, 1'(k)));
         end
      end
      ref_valid = 1'b1; ref_tag = {Q1, P1, 1'b1};
   endtask

   task automatic test_stale_backpressure();
      bit tmo, st; int inv_n, inv_at, exp_at, rsp_at, br; logic [MW-1:0] rm; logic re, rh, ra;
      logic [MW-1:0] m = {8{$urandom}};
      run_job(Q1, P1, m, 1'b1, 1'b0, 20, -1, tmo, inv_n, inv_at, exp_at, rsp_at, br, rm, re, rh, st, ra);
      checks++;
      if (tmo || rsp_at != EXP_PHASE || rh !== 1'b1) begin
         errors++;
         $display("[TB] FAIL stale_guard rsp_at=%0d hit=%b want %0d/1", rsp_at, rh, EXP_PHASE);
      end
      checks++;
      if (!st || ra !== 1'b1 || rm !== core_fn(Q1, P1, m, 1'b1)) begin
         errors++;
         $display("[TB] FAIL backpressure stable=%0d ready_after=%b msg=%h want 1/1/%h",
                  st, ra, rm, core_fn(Q1, P1, m, 1'b1));
      end
   endtask

   task automatic test_timeout();
      int inv_at, exp_n, rsp_at, w;
      for (int rep = 0; rep < 2; rep++) begin
         @(negedge clk);
         w = 0;
         while (!req_ready_to && w < 300) begin
            @(negedge clk);
            w++;
         end
         req_p = P1; req_q = Q1; req_msg = 256'h1234; req_decrypt = 1'b0;
         req_valid_to = 1'b1;
         @(negedge clk);
         req_valid_to = 1'b0;
         inv_at = -1; exp_n = 0; rsp_at = -1;
         for (int n = 0; n < 300; n++) begin
            if (n > 0) @(negedge clk);
            if (core_reset_inverter_to && inv_at < 0) inv_at = n;
            if (core_reset_mod_exp_to) exp_n++;
            if (rsp_valid_to) begin rsp_at = n; break; end
         end
         // One pulse cycle followed by TO_CYCLES wait cycles before the abort.
         checks++;
         if (inv_at != 0 || exp_n != 0 || rsp_at != TO_CYCLES + 1) begin
            errors++;
            $display("[TB] FAIL timeout_timing rep=%0d inv_at=%0d exp_n=%0d rsp_at=%0d want 0/0/%0d",
                     rep, inv_at, exp_n, rsp_at, TO_CYCLES + 1);
         end
         checks++;
         if (rsp_error_to !== 1'b1 || rsp_msg_to !== '0 || rsp_key_hit_to !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_rsp rep=%0d err=%b msg=%h hit=%b want 1/0/0",
                     rep, rsp_error_to, rsp_msg_to, rsp_key_hit_to);
         end
         rsp_ready_to = 1'b1;
         @(negedge clk);
         rsp_ready_to = 1'b0;
      end
   endtask

   task automatic test_flush();
      bit tmo, st; int inv_n, inv_at, exp_at, rsp_at, br; logic [MW-1:0] rm; logic re, rh, ra;
      logic exp_hit;
      for (int step = 0; step < 5; step++) begin
         logic fl_acc;
         int   fl_mid;
         fl_acc = (step == 2);
         fl_mid = (step == 0) ? 10 : -1;
         if (step == 4) begin
            @(negedge clk);
            key_flush = 1'b1;
            @(negedge clk);
            key_flush = 1'b0;
            ref_valid = 1'b0;
         end
         exp_hit = ref_valid && (ref_tag == {P2, Q2, 1'b0}) && !fl_acc;
         run_job(P2, Q2, 256'h55aa, 1'b0, fl_acc, 0, fl_mid, tmo, inv_n, inv_at, exp_at, rsp_at, br,
                 rm, re, rh, st, ra);
         checks++;
         if (tmo || rh !== exp_hit || inv_n != (exp_hit ? 0 : 1)) begin
            errors++;
            $display("[TB] FAIL flush_step%0d hit=%b inv_n=%0d want hit=%b", step, rh, inv_n, exp_hit);
         end
         ref_valid = (step != 0); ref_tag = {P2, Q2, 1'b0};
      end
   endtask

   task automatic test_random();
      bit tmo, st; int inv_n, inv_at, exp_at, rsp_at, br; logic [MW-1:0] rm; logic re, rh, ra;
      logic [W-1:0] p, q; logic [MW-1:0] m; logic d, fl, exp_hit; int k, hold;
      for (int j = 0; j < 12; j++) begin
         k = $urandom_range(0, 2);
         p = (k == 0) ? P1 : (k == 1) ? Q1 : P2;
         q = (k == 0) ? Q1 : (k == 1) ? P1 : Q2;
         d = 1'($urandom_range(0, 1));
         m = {8{$urandom}};
         fl = ($urandom_range(0, 3) == 0);
         hold = $urandom_range(0, 3);
         exp_hit = ref_valid && (ref_tag == {p, q, d}) && !fl;
         run_job(p, q, m, d, fl, hold, -1, tmo, inv_n, inv_at, exp_at, rsp_at, br, rm, re, rh, st, ra);
         checks++;
         if (tmo || rh !== exp_hit || rsp_at != (exp_hit ? EXP_PHASE : INV_PHASE + EXP_PHASE)) begin
            errors++;
            $display("[TB] FAIL rand%0d hit=%b rsp_at=%0d want hit=%b", j, rh, rsp_at, exp_hit);
         end
         checks++;
         if (rm !== core_fn(p, q, m, d) || re !== 1'b0 || !st) begin
            errors++;
            $display("[TB] FAIL rand%0d_rsp msg=%h err=%b stable=%0d want %h/0/1", j, rm, re, st,
                     core_fn(p, q, m, d));
         end
         ref_valid = 1'b1; ref_tag = {p, q, d};
      end
   endtask

   task automatic test_reset_mid_job();
      bit tmo, st; int inv_n, inv_at, exp_at, rsp_at, br; logic [MW-1:0] rm; logic re, rh, ra;
      bit seen; int bad, w;
      @(negedge clk);
      w = 0;
      while (!req_ready && w < 300) begin
         @(negedge clk);
         w++;
      end
      req_p = P1; req_q = Q1; req_msg = 256'h77; req_decrypt = 1'b0; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      seen = 0;
      for (int n = 0; n < 300; n++) begin
         if (core_reset_mod_exp) begin seen = 1; break; end
         @(negedge clk);
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("[TB] FAIL midjob_reach got=no_modexp_pulse want=pulse");
      end
      repeat (10) @(negedge clk);
      reset_n = 1'b0;
      #1;
      checks++;
      if ({req_ready, rsp_valid, rsp_error, rsp_key_hit, core_reset_inverter,
           core_reset_mod_exp} !== 6'b100000 || core_p !== '0 || core_msg_in !== '0) begin
         errors++;
         $display("[TB] FAIL midjob_reset ctrl=%b core_p=%h want 100000/0", {req_ready, rsp_valid,
                  rsp_error, rsp_key_hit, core_reset_inverter, core_reset_mod_exp}, core_p);
      end
      @(negedge clk);
      reset_n = 1'b1;
      bad = 0;
      for (int n = 0; n < 150; n++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0 || req_ready !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("[TB] FAIL midjob_quiet bad_cycles=%0d want 0", bad);
      end
      ref_valid = 1'b0;
      run_job(P1, Q1, 256'h99, 1'b0, 1'b0, 0, -1, tmo, inv_n, inv_at, exp_at, rsp_at, br, rm, re, rh, st, ra);
      checks++;
      if (tmo || rh !== 1'b0 || inv_n != 1 || rm !== core_fn(P1, Q1, 256'h99, 1'b0)) begin
         errors++;
         $display("[TB] FAIL after_reset hit=%b inv_n=%0d msg=%h want 0/1/%h", rh, inv_n, rm,
                  core_fn(P1, Q1, 256'h99, 1'b0));
      end
   endtask

   initial begin
      test_reset();
      test_miss_encrypt();
      test_hit();
      test_swapped_key();
      test_stale_backpressure();
      test_timeout();
      test_flush();
      test_random();
      test_reset_mid_job();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #800000;
      $display("[TB] FAIL global_timeout sim_time=%0t limit reached", $time);
      $fatal(1, "[TB] simulation did not finish");
   end

endmodule

// File: doc/rsa_job_sequencer.md
Name: rsa_job_sequencer

Overview:
- Front-end controller for one RSA `control` core instance.
- Accepts encrypt/decrypt jobs (p, q, message, direction) over a valid/ready request channel and sequences the core: inverter reset pulse, wait for inverter_finish, mod-exp reset pulse, wait for mod_exp_finish.
- Returns the result over a valid/ready response channel.
- Caches the last key so back-to-back jobs with the same key and direction skip the inverter phase. A watchdog aborts hung phases.

Parameters:
- WIDTH, 128, prime width; message width is 2*WIDTH.
- TIMEOUT_CYCLES, 1048576, maximum cycles allowed in one wait phase before abort.
- CNT_W, 21, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  job request valid.
- req_ready  out  1  sequencer can accept a job.
- req_p  in  WIDTH  prime p.
- req_q  in  WIDTH  prime q.
- req_msg  in  2*WIDTH  input message.
- req_decrypt  in  1  direction: 0 = encrypt, 1 = decrypt; drives core encrypt_decrypt.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_msg  out  2*WIDTH  result message; zero on error.
- rsp_error  out  1  job aborted by watchdog.
- rsp_key_hit  out  1  inverter phase was skipped.
- key_flush  in  1  invalidate key cache.
- core_p  out  WIDTH  to core p.
- core_q  out  WIDTH  to core q.
- core_msg_in  out  2*WIDTH  to core msg_in.
- core_encrypt_decrypt  out  1  to core.
- core_reset_inverter  out  1  one-cycle start pulse to inverter.
- core_reset_mod_exp  out  1  one-cycle start pulse to mod-exp.
- core_inverter_finish  in  1  from core.
- core_mod_exp_finish  in  1  from core.
- core_msg_out  in  2*WIDTH  from core.

Behaviour:
Reset values (reset_n low, asynchronous):
- State IDLE, req_ready=1, rsp_valid=0, rsp_msg=0, rsp_error=0, rsp_key_hit=0.
- Both core resets 0, all core data outputs 0, key_valid=0, watchdog=0.

States: IDLE, INV_START, INV_WAIT, EXP_START, EXP_WAIT, RESP.
- IDLE: req_ready=1.
  - On req_valid, register p, q, msg and decrypt into the core_* outputs; these stay stable until the next accept.
  - If key_valid and {p, q, decrypt} equal the cached tag: go to EXP_START with hit=1.
  - Otherwise: go to INV_START with hit=0.
- INV_START: core_reset_inverter=1 for exactly one cycle, clear watchdog, then go to INV_WAIT.
- INV_WAIT:
  - The first cycle is a guard cycle; core_inverter_finish is ignored there because it may be stale from the previous job.
  - From the second cycle on, finish=1: store the tag, set key_valid=1, go to EXP_START.
  - Watchdog reaching TIMEOUT_CYCLES: set error, clear key_valid, go to RESP.
- EXP_START: core_reset_mod_exp=1 for exactly one cycle, clear watchdog, then go to EXP_WAIT.
- EXP_WAIT: same guard-cycle rule as INV_WAIT.
  - finish=1: capture core_msg_out into rsp_msg, go to RESP.
  - Timeout: set error, rsp_msg=0, clear key_valid, go to RESP.
- RESP: rsp_valid=1 with rsp_error and rsp_key_hit; rsp_* are held stable while rsp_valid=1 and rsp_ready=0. On rsp_ready, go to IDLE.
  - There is no bypass; req_ready rises the cycle after the response handshake.

Rules and boundary conditions:
- req_ready=1 only in IDLE; requests seen in any other state are not accepted.
- Latency on miss, counted from the accept edge: inverter pulse at +1. Latency on hit: mod-exp pulse at +1.
- Watchdog increments every wait cycle, including the guard cycle, and saturates.
- key_flush:
  - In IDLE, or coincident with an accept, flush wins: key_valid=0 and the job is treated as a miss.
  - While busy: a pending-flush flag is set and key_valid is cleared on return to IDLE, after any tag store.
- Finish and timeout in the same cycle: finish wins.
- reset_n asserted mid-job: immediate return to the reset state, with no response emitted.
- The tag comparison is an exact 2*WIDTH+1-bit equality.

Decomposition:
- Shared package rsa_pkg holds:
  - the state enum `seq_state_t`;
  - `RSA_WIDTH=128`;
  - the message width `2*RSA_WIDTH`;
  - the default timeout constant.
- One sub-module, rsa_key_cache: tag register, key_valid, pending flush, compare output. It is separated for reuse with a future multi-core arbiter.
- The watchdog counter stays inline.

Test Plan:
Bench setup: behavioural core model with inverter latency 40 and mod-exp latency 100; finish stays high until the next reset pulse.
1. Miss, encrypt: p=113680897410347, q=7999808077935876437321, msg=0xb3000000000000, decrypt=0.
   - Inverter pulse at +1, mod-exp pulse after finish, rsp_valid with model output.
   - rsp_key_hit=0, rsp_error=0.
2. Hit: same p/q/direction with msg=0xe149.
   - No core_reset_inverter pulse; mod-exp pulse at +1; rsp_key_hit=1.
3. Swapped key: p=7999808077935876437321, q=113680897410347.
   - Miss; inverter pulse occurs.
   - Then decrypt=1 with the same key: also a miss (direction is part of the tag).
4. Stale finish and backpressure:
   - Model holds finish=1 from the prior job; the guard cycle must not advance the state.
   - Hold rsp_ready=0 for 20 cycles: rsp_msg stable, req_ready=0.
5. Timeout, with TIMEOUT_CYCLES=64 and the model never finishing the inverter:
   - rsp_error=1 and rsp_msg=0 exactly 64 wait cycles after the pulse.
   - The next identical job is a miss.
6. Flush and reset:
   - key_flush mid-job, then the same key: it must miss.
   - reset_n low during EXP_WAIT: all outputs return to reset values, no rsp_valid, req_ready=1 after release.
